// File: rtl/rand_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : rand_dispatch
// Brief    : Rule 30 cellular-automaton random source shared by N_REQ
//            consumers through a round-robin req/ack arbiter.
// Revision : 1.0  initial release
// ============================================================================
module rand_dispatch #(
    parameter int unsigned N_REQ = 4,
    parameter logic [31:0] SEED  = 32'h5A39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             seed_ld,
    input  logic [31:0]      seed_val,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [2:0]       ack_id,
    output logic [31:0]      rnd_out,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_RESEED = 1'b1
    } fsm_t;

    localparam logic [N_REQ-1:0] C_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    fsm_t             fsm_q;
    logic [31:0]      state_q;
    logic [31:0]      state_d;
    logic [31:0]      seed_fix;
    logic [2:0]       rr_q;
    logic [2:0]       rr_d;
    logic [N_REQ-1:0] ack_q;
    logic [2:0]       ack_id_q;
    logic [31:0]      rnd_q;
    logic             busy_q;

    logic [N_REQ-1:0] rr_mask;
    logic [N_REQ-1:0] req_hi;
    logic [N_REQ-1:0] pick;
    logic [2:0]       win_id;
    logic             win_vld;

    // Cyclic Rule 30: left neighbour is a rotate-left, right neighbour a rotate-right.
    assign state_d  = {state_q[30:0], state_q[31]} ^ (state_q | {state_q[0], state_q[31:1]});
    assign seed_fix = (seed_val == 32'h0) ? SEED : seed_val;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
    assign rr_mask = ~((C_ONE << rr_q) - C_ONE);
    assign req_hi  = req & rr_mask;

    always_comb begin
        win_vld = |req;
        win_id  = '0;
        pick    = (|req_hi) ? req_hi : req;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (pick[j]) begin
                win_id = 3'(j);
            end
        end
    end

    assign rr_d = (win_id == 3'(N_REQ - 1)) ? 3'd0 : win_id + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= S_RUN;
            state_q  <= SEED;
            rr_q     <= '0;
            ack_q    <= '0;
            ack_id_q <= '0;
            rnd_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            busy_q <= 1'b0;
            if (seed_ld) begin
                // A reload always restarts the one-cycle RESEED window.
                state_q <= seed_fix;
                fsm_q   <= S_RESEED;
                busy_q  <= 1'b1;
            end else if (fsm_q == S_RESEED) begin
                fsm_q <= S_RUN;
            end else if (!pause) begin
                state_q <= state_d;
                if (win_vld) begin
                    ack_q    <= C_ONE << win_id;
                    ack_id_q <= win_id;
                    rnd_q    <= state_q;
                    rr_q     <= rr_d;
                end
            end
        end
    end

    assign ack     = ack_q;
    assign ack_id  = ack_id_q;
    assign rnd_out = rnd_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
